// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair of a 4:1 mux, with a bounded hold per tenure.
// Optional build macro MUX4_ARB_PARK_EN: in IDLE the select/idx hold the last owner instead of A.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic [1:0] idx
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic             state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             busy_q, busy_d;

  logic [2:0] pick_idle_c;
  logic [2:0] pick_rel_c;
  logic       release_c;

  // First requester at or above pointer p (wrapping); returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      c = p + 2'(i);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign pick_idle_c = rr_pick(req, ptr_q);
  assign pick_rel_c  = rr_pick(req, idx_q + 2'd1);
  assign release_c   = !req[idx_q] || (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_idle_c[2]) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << pick_idle_c[1:0];
          idx_d   = pick_idle_c[1:0];
          hold_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          // Re-arbitrate in the same edge so a waiting requester sees no bubble.
          ptr_d = idx_q + 2'd1;
          if (pick_rel_c[2]) begin
            gnt_d  = 4'b0001 << pick_rel_c[1:0];
            idx_d  = pick_rel_c[1:0];
            hold_d = '0;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            hold_d  = '0;
`ifdef MUX4_ARB_PARK_EN
            idx_d   = idx_q;
`else
            idx_d   = 2'd0;
`endif
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  // Selects mirror the registered owner index: s0 is the MSB, s1 the LSB.
  assign gnt  = gnt_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign s0   = idx_q[1];
  assign s1   = idx_q[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD=8 and 2) checked against a tenure-counting model.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt8, gnt2;
  logic       s0_8, s1_8, busy8, s0_2, s1_2, busy2;
  logic [1:0] idx8, idx2;

  int total = 0;
  int bad   = 0;

  int m_owner [2];
  int m_ptr   [2];
  int m_ten   [2];
  bit m_busy  [2];
  int m_max   [2];

  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt8),
    .s0(s0_8), .s1(s1_8), .busy(busy8), .idx(idx8)
  );

  mux4_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt2),
    .s0(s0_2), .s1(s1_2), .busy(busy2), .idx(idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Model: m_ten counts cycles the owner has held the mux in the current tenure.
  task automatic model_edge(input int k);
    int w;
    if (rst) begin
      m_busy[k] = 1'b0; m_ptr[k] = 0; m_ten[k] = 0; m_owner[k] = 0;
    end else if (!m_busy[k]) begin
      w = pick(req, m_ptr[k]);
      if (w >= 0) begin m_busy[k] = 1'b1; m_owner[k] = w; m_ten[k] = 1; end
    end else if (!req[m_owner[k]] || m_ten[k] >= m_max[k]) begin
      m_ptr[k] = (m_owner[k] + 1) % 4;
      w = pick(req, m_ptr[k]);
      if (w >= 0) begin m_owner[k] = w; m_ten[k] = 1; end
      else m_busy[k] = 1'b0;
    end else begin
      m_ten[k] = m_ten[k] + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int k);
    return m_busy[k] ? (4'b0001 << m_owner[k]) : 4'b0000;
  endfunction

  function automatic logic [1:0] exp_idx(input int k);
`ifdef MUX4_ARB_PARK_EN
    return 2'(m_owner[k]);
`else
    return m_busy[k] ? 2'(m_owner[k]) : 2'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("gnt8",  8'(gnt8),          8'(exp_gnt(0)));
    chk("busy8", 8'(busy8),         8'(m_busy[0]));
    chk("idx8",  8'(idx8),          8'(exp_idx(0)));
    chk("sel8",  8'({s0_8, s1_8}),  8'(exp_idx(0)));
    chk("gnt2",  8'(gnt2),          8'(exp_gnt(1)));
    chk("busy2", 8'(busy2),         8'(m_busy[1]));
    chk("idx2",  8'(idx2),          8'(exp_idx(1)));
    chk("sel2",  8'({s0_2, s1_2}),  8'(exp_idx(1)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    m_max[0] = 8;
    m_max[1] = 2;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0; m_ptr[k] = 0; m_ten[k] = 0; m_busy[k] = 1'b0;
    end
    rst = 1'b1;
    req = 4'b1111;

    // Reset held two edges with all requesting.
    step();
    step();
    chk("t1_gnt_rst", 8'(gnt8), 8'h00);
    chk("t1_sel_rst", 8'({s0_8, s1_8}), 8'h00);
    rst = 1'b0;
    step();
    chk("t1_gnt_first", 8'(gnt8), 8'h01);

    // Lone requester C for three cycles, then drop.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_gnt", 8'(gnt8), 8'h04);
      chk("t2_sel", 8'({s0_8, s1_8}), 8'h02);
    end
    req = 4'b0000;
    step();
    chk("t2_idle", 8'(busy8), 8'h00);
    step();

    // Rotation with everyone requesting.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 34; i++) step();

    // Early release with no bubble.
    do_reset();
    req = 4'b0001;
    step();
    step();
    req = 4'b1010;
    step();
    chk("t4_no_bubble", 8'(gnt8), 8'h02);
    for (int i = 0; i < 10; i++) step();
    chk("t4_then_d", 8'(gnt8), 8'h08);

    // Lone expiry: owner re-granted, busy never drops.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_busy", 8'(busy8), 8'h01);
    end

    // Mid-tenure reset resets the pointer to A.
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    req = 4'b1001;
    step();
    chk("t6_rst_gnt", 8'(gnt8), 8'h00);
    chk("t6_rst_sel", 8'({s0_8, s1_8}), 8'h00);
    rst = 1'b0;
    step();
    chk("t6_first_a", 8'(gnt8), 8'h01);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
